// File: rtl/stream_decrypt_core.sv
// Two-stage stream decryption pipeline: XOR with a rotating round key, then rotate right.
module stream_decrypt_core #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NKEYS = 3,
  parameter int unsigned SH    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  key_we,
  input  logic [((NKEYS > 1) ? $clog2(NKEYS) : 1)-1:0] key_idx,
  input  logic [DW-1:0]                         key_data,
  input  logic [2:0]                            rot_freq,
  input  logic                                  restart,
  input  logic                                  in_valid,
  input  logic [DW-1:0]                         in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [DW-1:0]                         out_data,
  input  logic                                  out_ready
);

  localparam int unsigned KIW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int unsigned CW  = 3;

  logic [DW-1:0]  keyring [NKEYS];
  logic [KIW-1:0] ptr, ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           s1_valid;
  logic [DW-1:0]  s1_data;
  logic [DW-1:0]  s1_key;
  logic           advance;
  logic           accept;

  // Inverse permutation: rotate right by SH within DW bits.
  function automatic logic [DW-1:0] ror(input logic [DW-1:0] x);
    logic [2*DW-1:0] w;
    w = {x, x} >> SH;
    return w[DW-1:0];
  endfunction

  // Handshake: S2 drains when empty or sink ready; S1 refills when it can move on.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;

  // Next key pointer / beat counter; restart wins over a rotation step.
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (restart) begin
      ptr_nxt = '0;
      cnt_nxt = '0;
    end else if (accept && (rot_freq != '0)) begin
      if (({1'b0, cnt} + 4'd1) >= {1'b0, rot_freq}) begin
        cnt_nxt = '0;
        ptr_nxt = (ptr == KIW'(NKEYS - 1)) ? '0 : ptr + KIW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Key pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Key ring; writes to slots beyond the ring are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NKEYS; i++) keyring[i] <= '0;
    end else if (key_we && (32'(key_idx) < NKEYS)) begin
      keyring[key_idx] <= key_data;
    end
  end

  // S1: capture ciphertext together with the key current at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_key   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_key  <= keyring[ptr];
      end
    end
  end

  // S2: plaintext register, held while the sink stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= ror(s1_data ^ s1_key);
    end
  end

endmodule
